// File: rtl/commit_trace_checker_pkg.sv
// Shared definitions for the commit trace checker: entry layout, FSM states,
// mismatch_field bit positions and the register-write comparison rule.
package commit_trace_checker_pkg;

    localparam int unsigned ENTRY_W      = 102;
    localparam int unsigned OFS_PC       = 70;
    localparam int unsigned OFS_INST     = 38;
    localparam int unsigned OFS_RF_WE    = 37;
    localparam int unsigned OFS_RF_WADDR = 32;
    localparam int unsigned OFS_RF_WDATA = 0;

    localparam int unsigned MF_PC      = 0;
    localparam int unsigned MF_INST    = 1;
    localparam int unsigned MF_RF      = 2;
    localparam int unsigned MF_TIMEOUT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    // Field order matches the packed entry layout, pc in the top bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } entry_t;

    // A write to r0 counts as no write on either side.
    function automatic logic rf_differs(input entry_t a, input entry_t b);
        logic a_wr;
        logic b_wr;
        a_wr = a.rf_we && (a.rf_waddr != 5'd0);
        b_wr = b.rf_we && (b.rf_waddr != 5'd0);
        if (!a_wr && !b_wr) begin
            return 1'b0;
        end
        return (a_wr != b_wr) || (a.rf_waddr != b.rf_waddr) || (a.rf_wdata != b.rf_wdata);
    endfunction

endpackage

// File: rtl/commit_trace_checker_trace_mem_sp.sv
// Expected-trace storage: simple-dual-port RAM, synchronous write and read.
module trace_mem_sp
    import commit_trace_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/commit_trace_checker.sv
// Compares the CPU commit stream against a preloaded expected trace.
// Define COMMIT_TRACE_RFCHK_EN to also compare register-file writes.
module commit_trace_checker
    import commit_trace_checker_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 512,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    trace_len,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [ENTRY_W-1:0] load_data,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic [31:0]        commit_inst,
    input  logic               commit_rf_we,
    input  logic [4:0]         commit_rf_waddr,
    input  logic [31:0]        commit_rf_wdata,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [ADDR_W:0]    checked_cnt,
    output logic [ADDR_W-1:0]  mismatch_idx,
    output logic [3:0]         mismatch_field,
    output logic [31:0]        exp_pc,
    output logic [31:0]        got_pc
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(TRACE_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [ADDR_W:0]    len_q, len_d, idx_q, idx_d, cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               s1_vld_q, s1_vld_d;
    entry_t             s1_q, s1_d;
    logic [ADDR_W-1:0]  mis_idx_q, mis_idx_d;
    logic [3:0]         mis_field_q, mis_field_d;
    logic [31:0]        exp_pc_q, exp_pc_d, got_pc_q, got_pc_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;

    logic [ENTRY_W-1:0] rd_data;
    entry_t             exp_e;
    logic [ADDR_W:0]    len_clamp;
    logic               mem_we;
    logic [3:0]         field_now;

    trace_mem_sp #(
        .DEPTH (TRACE_DEPTH),
        .AW    (ADDR_W)
    ) u_mem (
        .clk   (clk_in),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state_q == ST_RUN),
        .raddr (idx_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign exp_e     = entry_t'(rd_data);
    assign mem_we    = load_we && (state_q != ST_RUN);
    assign len_clamp = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;

    always_comb begin
        field_now          = '0;
        field_now[MF_PC]   = (exp_e.pc != s1_q.pc);
        field_now[MF_INST] = (exp_e.inst != s1_q.inst);
`ifdef COMMIT_TRACE_RFCHK_EN
        field_now[MF_RF]   = rf_differs(exp_e, s1_q);
`else
        field_now[MF_RF]   = 1'b0;
`endif
    end

`ifndef COMMIT_TRACE_RFCHK_EN
    logic unused_rf;
    assign unused_rf = ^{exp_e.rf_we, exp_e.rf_waddr, exp_e.rf_wdata,
                         s1_q.rf_we, s1_q.rf_waddr, s1_q.rf_wdata};
`endif

    // Read address tracks idx every RUN cycle, so rd_data holds entry[idx]
    // while idle; the timeout path relies on that for exp_pc.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        s1_vld_d    = 1'b0;
        s1_d        = s1_q;
        mis_idx_d   = mis_idx_q;
        mis_field_d = mis_field_q;
        exp_pc_d    = exp_pc_q;
        got_pc_d    = got_pc_q;

        case (state_q)
            ST_RUN: begin
                to_d = commit_valid ? '0 : to_q + 1'b1;
                if (s1_vld_q && (field_now != '0)) begin
                    state_d     = ST_FAIL;
                    cnt_d       = cnt_q + 1'b1;
                    mis_idx_d   = cnt_q[ADDR_W-1:0];
                    mis_field_d = field_now;
                    exp_pc_d    = exp_e.pc;
                    got_pc_d    = s1_q.pc;
                end else if (s1_vld_q && ((cnt_q + 1'b1) == len_q)) begin
                    state_d = ST_PASS;
                    cnt_d   = cnt_q + 1'b1;
                end else if (!commit_valid && (to_q == TO_LAST)) begin
                    state_d                 = ST_FAIL;
                    mis_idx_d               = idx_q[ADDR_W-1:0];
                    mis_field_d             = '0;
                    mis_field_d[MF_TIMEOUT] = 1'b1;
                    exp_pc_d                = exp_e.pc;
                end else begin
                    if (s1_vld_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (commit_valid && (idx_q < len_q)) begin
                        s1_vld_d = 1'b1;
                        s1_d     = '{commit_pc, commit_inst, commit_rf_we,
                                     commit_rf_waddr, commit_rf_wdata};
                        idx_d    = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = (len_clamp == '0) ? ST_PASS : ST_RUN;
                    len_d       = len_clamp;
                    idx_d       = '0;
                    cnt_d       = '0;
                    to_d        = '0;
                    mis_idx_d   = '0;
                    mis_field_d = '0;
                    exp_pc_d    = '0;
                    got_pc_d    = '0;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL);
        done_d = pass_d || fail_d;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            s1_vld_q    <= 1'b0;
            s1_q        <= '0;
            mis_idx_q   <= '0;
            mis_field_q <= '0;
            exp_pc_q    <= '0;
            got_pc_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            s1_vld_q    <= s1_vld_d;
            s1_q        <= s1_d;
            mis_idx_q   <= mis_idx_d;
            mis_field_q <= mis_field_d;
            exp_pc_q    <= exp_pc_d;
            got_pc_q    <= got_pc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign checked_cnt    = cnt_q;
    assign mismatch_idx   = mis_idx_q;
    assign mismatch_field = mis_field_q;
    assign exp_pc         = exp_pc_q;
    assign got_pc         = got_pc_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed self-checking bench for commit_trace_checker; expectations follow
// COMMIT_TRACE_RFCHK_EN when it is defined.
module tb_commit_trace_checker;
    import commit_trace_checker_pkg::*;

    logic               clk_in = 1'b0;
    logic               reset;
    logic               start;
    logic [9:0]         trace_len;
    logic               load_we;
    logic [8:0]         load_addr;
    logic [ENTRY_W-1:0] load_data;
    logic               commit_valid;
    logic [31:0]        commit_pc;
    logic [31:0]        commit_inst;
    logic               commit_rf_we;
    logic [4:0]         commit_rf_waddr;
    logic [31:0]        commit_rf_wdata;
    logic               busy, done, pass, fail;
    logic [9:0]         checked_cnt;
    logic [8:0]         mismatch_idx;
    logic [3:0]         mismatch_field;
    logic [31:0]        exp_pc, got_pc;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] b_pc   [4];
    logic [31:0] b_inst [4];
    logic        b_we   [4];
    logic [4:0]  b_wa   [4];
    logic [31:0] b_wd   [4];

    commit_trace_checker #(
        .TRACE_DEPTH (512),
        .ADDR_W      (9),
        .TIMEOUT     (1024)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .start           (start),
        .trace_len       (trace_len),
        .load_we         (load_we),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_inst     (commit_inst),
        .commit_rf_we    (commit_rf_we),
        .commit_rf_waddr (commit_rf_waddr),
        .commit_rf_wdata (commit_rf_wdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .checked_cnt     (checked_cnt),
        .mismatch_idx    (mismatch_idx),
        .mismatch_field  (mismatch_field),
        .exp_pc          (exp_pc),
        .got_pc          (got_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_entry(input int unsigned a, input logic [31:0] pc, input logic [31:0] inst,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
        load_we   = 1'b1;
        load_addr = 9'(a);
        load_data = '0;
        load_data[OFS_PC +: 32]      = pc;
        load_data[OFS_INST +: 32]    = inst;
        load_data[OFS_RF_WE]         = we;
        load_data[OFS_RF_WADDR +: 5] = wa;
        load_data[OFS_RF_WDATA +: 32] = wd;
        tick();
        load_we = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] len);
        start     = 1'b1;
        trace_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        commit_valid    = 1'b1;
        commit_pc       = pc;
        commit_inst     = inst;
        commit_rf_we    = we;
        commit_rf_waddr = wa;
        commit_rf_wdata = wd;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic commit_base(input int unsigned i);
        commit(b_pc[i], b_inst[i], b_we[i], b_wa[i], b_wd[i]);
    endtask

    task automatic load_base();
        for (int i = 0; i < 4; i++) begin
            load_entry(i, b_pc[i], b_inst[i], b_we[i], b_wa[i], b_wd[i]);
        end
    endtask

    initial begin
        int unsigned waited;

        b_pc   = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
        b_inst = '{32'h3c01_0040, 32'h3424_0000, 32'h2008_0005, 32'h0109_4020};
        b_we   = '{1'b1, 1'b1, 1'b1, 1'b1};
        b_wa   = '{5'd1, 5'd4, 5'd8, 5'd8};
        b_wd   = '{32'h0040_0000, 32'h0040_0000, 32'h0000_0005, 32'h0000_000A};

        reset = 1'b1; start = 1'b0; trace_len = '0; load_we = 1'b0; load_addr = '0;
        load_data = '0; commit_valid = 1'b0; commit_pc = '0; commit_inst = '0;
        commit_rf_we = 1'b0; commit_rf_waddr = '0; commit_rf_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_cnt", 32'(checked_cnt), 32'd0);
        check("rst_field", 32'(mismatch_field), 32'd0);

        // 1: four matching commits back-to-back
        load_base();
        commit_base(0);
        check("idle_commit_ignored", 32'(checked_cnt), 32'd0);
        do_start(10'd4);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) commit_base(i);
        check("t1_pass_not_yet", 32'(pass), 32'd0);
        tick();
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_fail", 32'(fail), 32'd0);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_cnt", 32'(checked_cnt), 32'd4);

        // 2: wrong inst at entry 2; following commit hits the verdict edge
        do_start(10'd4);
        commit_base(0);
        commit_base(1);
        commit(b_pc[2], 32'h2008_0006, b_we[2], b_wa[2], b_wd[2]);
        commit_base(3);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_idx", 32'(mismatch_idx), 32'd2);
        check("t2_field", 32'(mismatch_field), 32'h2);
        check("t2_exp_pc", exp_pc, 32'h0040_0008);
        check("t2_got_pc", got_pc, 32'h0040_0008);
        commit_base(3);
        tick();
        check("t2_hold_fail", 32'(fail), 32'd1);
        check("t2_hold_idx", 32'(mismatch_idx), 32'd2);
        check("t2_hold_field", 32'(mismatch_field), 32'h2);

        // 5: reset mid-run, then restart with retained memory
        do_start(10'd4);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_field_cleared", 32'(mismatch_field), 32'd0);
        commit_base(0);
        commit_base(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_cnt", 32'(checked_cnt), 32'd0);
        check("t5_rst_fail", 32'(fail), 32'd0);
        do_start(10'd4);
        for (int i = 0; i < 4; i++) commit_base(i);
        tick();
        check("t5_pass", 32'(pass), 32'd1);
        check("t5_cnt", 32'(checked_cnt), 32'd4);

        // 3: register-write rules (r0 write equals no write)
        load_entry(0, 32'h0000_1000, 32'h1111_1111, 1'b0, 5'd0, 32'h0);
        do_start(10'd1);
        commit(32'h0000_1000, 32'h1111_1111, 1'b1, 5'd0, 32'h1234);
        tick();
        check("t3_r0_pass", 32'(pass), 32'd1);
        check("t3_r0_fail", 32'(fail), 32'd0);
        do_start(10'd1);
        commit(32'h0000_1000, 32'h1111_1111, 1'b1, 5'd8, 32'h1234);
        tick();
`ifdef COMMIT_TRACE_RFCHK_EN
        check("t3_r8_fail", 32'(fail), 32'd1);
        check("t3_r8_field", 32'(mismatch_field), 32'h4);
        check("t3_r8_idx", 32'(mismatch_idx), 32'd0);
`else
        check("t3_r8_pass", 32'(pass), 32'd1);
        check("t3_r8_field", 32'(mismatch_field), 32'h0);
`endif

        // 4: timeout after one commit
        load_base();
        do_start(10'd3);
        commit_base(0);
        waited = 0;
        while (!fail && waited < 1100) begin
            tick();
            waited++;
        end
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_cycles", waited, 32'd1024);
        check("t4_field", 32'(mismatch_field), 32'h8);
        check("t4_idx", 32'(mismatch_idx), 32'd1);
        check("t4_exp_pc", exp_pc, 32'h0040_0004);
        check("t4_cnt", 32'(checked_cnt), 32'd1);

        // 6: zero length and clamping
        do_start(10'd0);
        check("t6_zero_pass", 32'(pass), 32'd1);
        check("t6_zero_busy", 32'(busy), 32'd0);
        check("t6_zero_cnt", 32'(checked_cnt), 32'd0);
        for (int i = 0; i < 512; i++) begin
            load_entry(i, 32'(i) << 2, ~32'(i), 1'b0, 5'd0, 32'h0);
        end
        do_start(10'd600);
        for (int i = 0; i < 512; i++) begin
            commit(32'(i) << 2, ~32'(i), 1'b0, 5'd0, 32'h0);
            if (i == 200) begin
                do_start(10'd4);
                check("t6_start_ignored", 32'(busy), 32'd1);
            end
        end
        tick();
        check("t6_clamp_pass", 32'(pass), 32'd1);
        check("t6_clamp_cnt", 32'(checked_cnt), 32'd512);
        check("t6_clamp_fail", 32'(fail), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
